// File: rtl/simon_game_fsm.sv
// Simon game sequencer: plays a growing LFSR-derived colour sequence on four LEDs,
// checks the player's presses against it and reports win/lose with a one-cycle done pulse.
module simon_game_fsm #(
    parameter int          MAX_LEVEL      = 8,
    parameter int          SHOW_CYCLES    = 8,
    parameter int          GAP_CYCLES     = 4,
    parameter int          TIMEOUT_CYCLES = 64,
    parameter logic [7:0]  SEED           = 8'hA5
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       run,
    input  logic [3:0] btn_pulse,
    output logic [3:0] led,
    output logic       game_complete,
    output logic       win,
    output logic       lose,
    output logic [3:0] level
);

    localparam int CNT_MAX_A = (SHOW_CYCLES > GAP_CYCLES) ? SHOW_CYCLES : GAP_CYCLES;
    localparam int CNT_MAX   = (CNT_MAX_A > TIMEOUT_CYCLES) ? CNT_MAX_A : TIMEOUT_CYCLES;
    localparam int TW        = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

    localparam logic [TW-1:0] SHOW_LAST    = TW'(SHOW_CYCLES - 1);
    localparam logic [TW-1:0] GAP_LAST     = TW'(GAP_CYCLES - 1);
    localparam logic [TW-1:0] TIMEOUT_LAST = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [3:0]    MAX_LVL      = 4'(MAX_LEVEL);

    typedef enum logic [3:0] {
        S_IDLE,
        S_LOAD,
        S_PLAY_INIT,
        S_SHOW_ON,
        S_SHOW_OFF,
        S_INPUT_INIT,
        S_INPUT,
        S_WIN,
        S_LOSE,
        S_END
    } state_t;

    state_t          state;
    state_t          next_state;
    logic [7:0]      free_cnt;
    logic [7:0]      lfsr;
    logic [7:0]      seed_q;
    logic [3:0]      idx;
    logic [TW-1:0]   timer;

    logic [7:0]      lfsr_next;
    logic [7:0]      seed_mix;
    logic [3:0]      colour_hot;
    logic            press;
    logic            press_ok;
    logic            show_done;
    logic            gap_done;
    logic            timeout;
    logic            round_done;
    logic            at_max;

    assign lfsr_next  = {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
    assign seed_mix   = free_cnt ^ SEED;
    assign colour_hot = 4'b0001 << lfsr[1:0];
    assign press      = |btn_pulse;
    assign press_ok   = (btn_pulse == colour_hot);
    assign show_done  = (timer == SHOW_LAST);
    assign gap_done   = (timer == GAP_LAST);
    assign timeout    = (timer == TIMEOUT_LAST);
    assign round_done = ((idx + 4'd1) == level);
    assign at_max     = (level == MAX_LVL);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // A press is judged before the timeout, so a correct press on the last timer cycle still counts.
    always_comb begin
        next_state    = state;
        led           = 4'b0000;
        game_complete = 1'b0;
        case (state)
            S_IDLE:       if (run) next_state = S_LOAD;
            S_LOAD:       next_state = S_PLAY_INIT;
            S_PLAY_INIT:  next_state = S_SHOW_ON;
            S_SHOW_ON: begin
                led = colour_hot;
                if (show_done) next_state = S_SHOW_OFF;
            end
            S_SHOW_OFF: begin
                if (gap_done) next_state = (idx == level) ? S_INPUT_INIT : S_SHOW_ON;
            end
            S_INPUT_INIT: next_state = S_INPUT;
            S_INPUT: begin
                if (press) begin
                    if (!press_ok)       next_state = S_LOSE;
                    else if (round_done) next_state = at_max ? S_WIN : S_PLAY_INIT;
                end else if (timeout) begin
                    next_state = S_LOSE;
                end
            end
            S_WIN, S_LOSE: begin
                game_complete = 1'b1;
                next_state    = S_END;
            end
            S_END:        if (!run) next_state = S_IDLE;
            default:      next_state = S_IDLE;
        endcase
    end

    // free_cnt only counts idle cycles with run low, so the cycle that starts a game keeps the seed it saw.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            free_cnt <= 8'd0;
            lfsr     <= SEED;
            seed_q   <= SEED;
            idx      <= 4'd0;
            timer    <= '0;
            level    <= 4'd0;
            win      <= 1'b0;
            lose     <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (!run) free_cnt <= free_cnt + 8'd1;
                end
                S_LOAD: begin
                    seed_q <= (seed_mix == 8'd0) ? SEED : seed_mix;
                    level  <= 4'd1;
                    win    <= 1'b0;
                    lose   <= 1'b0;
                end
                S_PLAY_INIT, S_INPUT_INIT: begin
                    lfsr  <= seed_q;
                    idx   <= 4'd0;
                    timer <= '0;
                end
                S_SHOW_ON: begin
                    if (show_done) begin
                        timer <= '0;
                        lfsr  <= lfsr_next;
                        idx   <= idx + 4'd1;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                S_SHOW_OFF: begin
                    if (gap_done) timer <= '0;
                    else          timer <= timer + 1'b1;
                end
                S_INPUT: begin
                    if (press && press_ok) begin
                        lfsr  <= lfsr_next;
                        idx   <= idx + 4'd1;
                        timer <= '0;
                        if (round_done && !at_max) level <= level + 4'd1;
                    end else if (!press && !timeout) begin
                        timer <= timer + 1'b1;
                    end
                end
                S_END: begin
                    if (!run) level <= 4'd0;
                end
                default: ;
            endcase
            // Flags are set on entry so they are already valid alongside the completion pulse.
            if (next_state == S_WIN)  win  <= 1'b1;
            if (next_state == S_LOSE) lose <= 1'b1;
        end
    end

endmodule

// File: tb/tb_simon_game_fsm.sv
// Directed self-checking bench for simon_game_fsm (MAX_LEVEL=2); all stimulus and
// sampling happen on the falling clock edge, expected values are hand-derived.
module tb_simon_game_fsm;

    logic       clk;
    logic       rst;
    logic       run;
    logic [3:0] btn_pulse;
    logic [3:0] led;
    logic       game_complete;
    logic       win;
    logic       lose;
    logic [3:0] level;

    int checks;
    int failures;

    simon_game_fsm #(
        .MAX_LEVEL      (2),
        .SHOW_CYCLES    (8),
        .GAP_CYCLES     (4),
        .TIMEOUT_CYCLES (64),
        .SEED           (8'hA5)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .run           (run),
        .btn_pulse     (btn_pulse),
        .led           (led),
        .game_complete (game_complete),
        .win           (win),
        .lose          (lose),
        .level         (level)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check_output(input string tag, input logic [7:0] observed, input logic [7:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            failures++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic check_all_clear(input string tag);
        check_output({tag, "_led"},   {4'd0, led},   8'h00);
        check_output({tag, "_gc"},    {7'd0, game_complete}, 8'h00);
        check_output({tag, "_win"},   {7'd0, win},   8'h00);
        check_output({tag, "_lose"},  {7'd0, lose},  8'h00);
        check_output({tag, "_level"}, {4'd0, level}, 8'h00);
    endtask

    initial begin
        checks    = 0;
        failures  = 0;
        rst       = 1'b1;
        run       = 1'b0;
        btn_pulse = 4'b0000;
        tick(2);
        check_all_clear("reset");

        // Game 1: seed A5 -> colours 0010, 0100; won at level 2.
        rst = 1'b0;
        run = 1'b1;
        tick(1);
        check_output("load_led", {4'd0, led}, 8'h00);
        tick(1);
        check_output("pinit_level", {4'd0, level}, 8'h01);
        check_output("pinit_led", {4'd0, led}, 8'h00);
        tick(1);
        check_output("g1_show_first", {4'd0, led}, 8'h02);
        tick(7);
        check_output("g1_show_last", {4'd0, led}, 8'h02);
        tick(1);
        check_output("g1_gap_first", {4'd0, led}, 8'h00);
        tick(3);
        check_output("g1_gap_last", {4'd0, led}, 8'h00);
        check_output("g1_level1", {4'd0, level}, 8'h01);
        tick(2);
        btn_pulse = 4'b0010;
        tick(1);
        btn_pulse = 4'b0000;
        check_output("g1_level2", {4'd0, level}, 8'h02);
        check_output("g1_input_led", {4'd0, led}, 8'h00);
        tick(1);
        check_output("g1_r2_colour0", {4'd0, led}, 8'h02);
        tick(12);
        check_output("g1_r2_colour1", {4'd0, led}, 8'h04);
        tick(7);
        check_output("g1_r2_colour1_end", {4'd0, led}, 8'h04);
        tick(1);
        check_output("g1_r2_gap", {4'd0, led}, 8'h00);
        tick(5);
        btn_pulse = 4'b0010;
        tick(1);
        btn_pulse = 4'b0100;
        tick(1);
        btn_pulse = 4'b0000;
        check_output("win_pulse", {7'd0, game_complete}, 8'h01);
        check_output("win_flag", {7'd0, win}, 8'h01);
        check_output("win_level", {4'd0, level}, 8'h02);
        tick(1);
        check_output("win_pulse_gone", {7'd0, game_complete}, 8'h00);
        tick(4);
        check_output("end_hold_level", {4'd0, level}, 8'h02);
        check_output("end_hold_win", {7'd0, win}, 8'h01);
        check_output("end_hold_led", {4'd0, led}, 8'h00);
        run = 1'b0;
        tick(1);
        check_output("idle_level", {4'd0, level}, 8'h00);
        check_output("idle_win_sticky", {7'd0, win}, 8'h01);
        tick(1);

        // Game 2: one idle cycle with run low -> free_cnt=1, seed A4, colour 0001; wrong press loses.
        run = 1'b1;
        tick(1);
        check_output("load_win_kept", {7'd0, win}, 8'h01);
        tick(1);
        check_output("load_win_cleared", {7'd0, win}, 8'h00);
        check_output("g2_level", {4'd0, level}, 8'h01);
        tick(1);
        check_output("g2_show", {4'd0, led}, 8'h01);
        tick(1);
        btn_pulse = 4'b1000;
        tick(1);
        btn_pulse = 4'b0000;
        check_output("g2_press_ignored", {4'd0, led}, 8'h01);
        tick(5);
        check_output("g2_show_last", {4'd0, led}, 8'h01);
        tick(1);
        check_output("g2_gap", {4'd0, led}, 8'h00);
        tick(5);
        btn_pulse = 4'b0100;
        tick(1);
        btn_pulse = 4'b0000;
        check_output("lose_pulse", {7'd0, game_complete}, 8'h01);
        check_output("lose_flag", {7'd0, lose}, 8'h01);
        check_output("lose_win_flag", {7'd0, win}, 8'h00);
        check_output("lose_level", {4'd0, level}, 8'h01);
        tick(1);
        check_output("lose_pulse_gone", {7'd0, game_complete}, 8'h00);
        check_output("lose_end_level", {4'd0, level}, 8'h01);
        run = 1'b0;
        tick(1);
        check_output("lose_idle_level", {4'd0, level}, 8'h00);
        check_output("lose_idle_sticky", {7'd0, lose}, 8'h01);

        // Game 3: no press -> timeout loss after 64 input cycles (seed A4 again).
        run = 1'b1;
        tick(3);
        check_output("g3_show", {4'd0, led}, 8'h01);
        tick(13);
        tick(63);
        check_output("to_last_gc", {7'd0, game_complete}, 8'h00);
        check_output("to_last_lose", {7'd0, lose}, 8'h00);
        tick(1);
        check_output("to_pulse", {7'd0, game_complete}, 8'h01);
        check_output("to_lose", {7'd0, lose}, 8'h01);
        tick(1);
        run = 1'b0;
        tick(1);

        // Game 4: correct press on the final timer cycle beats the timeout.
        run = 1'b1;
        tick(3);
        check_output("g4_show", {4'd0, led}, 8'h01);
        tick(13);
        tick(63);
        btn_pulse = 4'b0001;
        tick(1);
        btn_pulse = 4'b0000;
        check_output("late_press_level", {4'd0, level}, 8'h02);
        check_output("late_press_lose", {7'd0, lose}, 8'h00);
        check_output("late_press_gc", {7'd0, game_complete}, 8'h00);
        tick(1);
        check_output("g4_r2_show", {4'd0, led}, 8'h01);
        tick(2);

        // Reset in the middle of SHOW_ON clears outputs immediately.
        rst = 1'b1;
        #1;
        check_all_clear("rst_show");
        tick(1);
        rst = 1'b0;
        tick(3);
        check_output("g5_show", {4'd0, led}, 8'h02);
        tick(15);

        // Reset in the middle of INPUT.
        rst = 1'b1;
        #1;
        check_all_clear("rst_input");
        tick(1);
        check_output("rst_input_no_pulse", {7'd0, game_complete}, 8'h00);
        rst = 1'b0;
        tick(16);

        // Multi-hot press that includes the correct colour still loses.
        btn_pulse = 4'b0011;
        tick(1);
        btn_pulse = 4'b0000;
        check_output("multihot_pulse", {7'd0, game_complete}, 8'h01);
        check_output("multihot_lose", {7'd0, lose}, 8'h01);
        tick(1);
        check_output("multihot_pulse_gone", {7'd0, game_complete}, 8'h00);
        run = 1'b0;
        tick(1);
        check_output("final_idle_level", {4'd0, level}, 8'h00);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
